// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among num_req producers.
// Each grant lasts up to max_burst accepted beats; an idle cycle separates grants.
module fifo_wr_arbiter #(
    parameter int num_req    = 4,
    parameter int data_width = 8,
    parameter int max_burst  = 4
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic [num_req-1:0]            req,
    input  logic [num_req*data_width-1:0] req_data,
    output logic [num_req-1:0]            gnt,
    output logic [num_req-1:0]            accept,
    output logic [$clog2(num_req)-1:0]    owner,
    output logic                          busy,
    input  logic                          fifo_full,
    output logic                          fifo_w_en,
    output logic [data_width-1:0]         fifo_data
);
    localparam int ow = $clog2(num_req);
    localparam int bw = (max_burst > 1) ? $clog2(max_burst) : 1;
    localparam logic [bw-1:0] last_beat = bw'(max_burst - 1);
    localparam logic [ow-1:0] last_req  = ow'(num_req - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t               state, state_nx;
    logic [num_req-1:0]   gnt_nx;
    logic [ow-1:0]        owner_nx, rr_ptr, rr_nx, pick;
    logic [bw-1:0]        beat_cnt, cnt_nx;
    logic                 found, release_now;
    int                   idx;

    assign accept    = gnt & req & {num_req{~fifo_full}};
    assign fifo_w_en = |accept;
    assign fifo_data = req_data[owner*data_width +: data_width];
    assign busy      = (state == BURST);

    // First requester at or after rr_ptr, wrapping explicitly so any num_req works.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < num_req; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= num_req) idx = idx - num_req;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = ow'(idx);
            end
        end
    end

    always_comb begin
        state_nx    = state;
        gnt_nx      = gnt;
        owner_nx    = owner;
        rr_nx       = rr_ptr;
        cnt_nx      = beat_cnt;
        release_now = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nx       = BURST;
                    gnt_nx         = '0;
                    gnt_nx[pick]   = 1'b1;
                    owner_nx       = pick;
                    cnt_nx         = '0;
                end
            end
            BURST: begin
                // A dropped request releases without a write; a full FIFO just stalls.
                release_now = !req[owner] || (!fifo_full && beat_cnt == last_beat);
                if (release_now) begin
                    state_nx = IDLE;
                    gnt_nx   = '0;
                    cnt_nx   = '0;
                    rr_nx    = (owner == last_req) ? '0 : owner + 1'b1;
                end else if (!fifo_full) begin
                    cnt_nx = beat_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nx;
            gnt      <= gnt_nx;
            owner    <= owner_nx;
            rr_ptr   <= rr_nx;
            beat_cnt <= cnt_nx;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed table, corner-case sequences and random
// traffic, all compared against a cycle-level model of the arbitration rules.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            clr;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    gnt, accept;
    logic [1:0]      owner;
    logic            busy, fifo_full, fifo_w_en;
    logic [DW-1:0]   fifo_data;

    fifo_wr_arbiter #(.num_req(N), .data_width(DW), .max_burst(MB)) dut (
        .clk(clk), .clr(clr), .req(req), .req_data(req_data), .gnt(gnt),
        .accept(accept), .owner(owner), .busy(busy), .fifo_full(fifo_full),
        .fifo_w_en(fifo_w_en), .fifo_data(fifo_data)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: current grantee (-1 when idle), beats taken, round-robin start, last grantee.
    int m_own, m_beats, m_rr, m_last;

    logic [N-1:0] o_gnt;
    logic         o_wen, o_busy;
    logic [1:0]   o_own;
    logic [DW-1:0] o_data;

    typedef struct {
        logic [N-1:0] req;
        logic         full;
        logic [N-1:0] exp_gnt;
        logic         exp_wen;
        logic [1:0]   exp_own;
        logic         exp_busy;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic c, input logic [N-1:0] r, input logic f,
                        input logic [N*DW-1:0] d);
        logic [N-1:0] e_gnt, e_acc;
        logic         rel;
        clr = c; req = r; fifo_full = f; req_data = d;
        @(negedge clk);
        e_gnt = '0;
        if (m_own >= 0) e_gnt[m_own] = 1'b1;
        e_acc = f ? '0 : (e_gnt & r);
        o_gnt = gnt; o_wen = fifo_w_en; o_busy = busy; o_own = owner; o_data = fifo_data;
        chk("gnt", gnt, e_gnt);
        chk("accept", accept, e_acc);
        chk("fifo_w_en", fifo_w_en, e_acc != 0);
        chk("owner", owner, m_last);
        chk("busy", busy, m_own >= 0);
        if (e_acc != 0) chk("fifo_data", fifo_data, d[m_own*DW +: DW]);
        @(posedge clk);
        rel = 1'b0;
        if (c) begin
            m_own = -1; m_beats = 0; m_rr = 0; m_last = 0;
        end else if (m_own < 0) begin
            for (int k = 0; k < N; k++)
                if (m_own < 0 && r[(m_rr + k) % N]) m_own = (m_rr + k) % N;
            if (m_own >= 0) begin m_last = m_own; m_beats = 0; end
        end else begin
            if (!r[m_own]) rel = 1'b1;
            else if (!f) begin
                m_beats++;
                if (m_beats == MB) rel = 1'b1;
            end
            if (rel) begin m_rr = (m_own + 1) % N; m_own = -1; m_beats = 0; end
        end
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, '0, 1'b0, '0);
    endtask

    initial begin
        int gcyc[$];
        int gown[$];
        int beats0;
        logic [N-1:0] prev;

        clr = 1'b1; req = '0; fifo_full = 1'b0; req_data = '0;
        @(posedge clk); #1;
        m_own = -1; m_beats = 0; m_rr = 0; m_last = 0;

        // Single requester holding for 6 beats: 4-beat burst, dead cycle, 2 more.
        tbl[0] = '{4'b0001, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[1] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1};
        tbl[2] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1};
        tbl[3] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1};
        tbl[4] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1};
        tbl[5] = '{4'b0001, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[6] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1};
        tbl[7] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1};
        tbl[8] = '{4'b0000, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b1};
        tbl[9] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            step(1'b0, tbl[i].req, tbl[i].full, {N{8'(i)}});
            chk("tbl_gnt", o_gnt, tbl[i].exp_gnt);
            chk("tbl_wen", o_wen, tbl[i].exp_wen);
            chk("tbl_owner", o_own, tbl[i].exp_own);
            chk("tbl_busy", o_busy, tbl[i].exp_busy);
            if (tbl[i].exp_wen) chk("tbl_data_order", o_data, 32'(i));
        end

        // All requesting: grants 0,1,2,3,0 every 5 cycles.
        do_reset();
        prev = '0;
        for (int c = 0; c < 25; c++) begin
            step(1'b0, 4'b1111, 1'b0, 32'h4433_2211);
            if (o_gnt != 0 && prev == 0) begin gcyc.push_back(c); gown.push_back(int'(o_own)); end
            prev = o_gnt;
        end
        chk("rr_grant_count", gown.size(), 5);
        for (int g = 0; g < 5 && g < gown.size(); g++) begin
            chk("rr_grant_owner", gown[g], g % N);
            chk("rr_grant_cycle", gcyc[g], 1 + 5 * g);
        end

        // Full FIFO stalls requester 2 after two beats.
        do_reset();
        step(1'b0, 4'b0100, 1'b0, 32'h0033_0000);
        step(1'b0, 4'b0100, 1'b0, 32'h0034_0000);
        step(1'b0, 4'b0100, 1'b0, 32'h0035_0000);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 4'b0100, 1'b1, 32'h0036_0000);
            chk("full_gnt_held", o_gnt, 4'b0100);
            chk("full_no_write", o_wen, 1'b0);
        end
        step(1'b0, 4'b0100, 1'b0, 32'h0036_0000);
        chk("full_beat3", o_wen, 1'b1);
        step(1'b0, 4'b0100, 1'b0, 32'h0037_0000);
        chk("full_beat4", o_wen, 1'b1);
        step(1'b0, 4'b0100, 1'b0, 32'h0038_0000);
        chk("full_released", o_gnt, 4'b0000);

        // Requester 0 drops after 2 beats; requester 1 follows.
        do_reset();
        beats0 = 0;
        step(1'b0, 4'b0011, 1'b0, 32'h0000_1101);
        for (int c = 0; c < 2; c++) begin
            step(1'b0, 4'b0011, 1'b0, 32'h0000_1101 + c);
            if (o_wen && o_gnt == 4'b0001) beats0++;
        end
        step(1'b0, 4'b0010, 1'b0, 32'h0000_1200);
        chk("drop_no_write", o_wen, 1'b0);
        chk("drop_gnt_still", o_gnt, 4'b0001);
        step(1'b0, 4'b0010, 1'b0, 32'h0000_1200);
        chk("drop_dead_cycle", o_gnt, 4'b0000);
        step(1'b0, 4'b0010, 1'b0, 32'h0000_1200);
        chk("drop_next_gnt", o_gnt, 4'b0010);
        chk("drop_beats_from_0", beats0, 2);

        // clr mid-burst of requester 3.
        do_reset();
        step(1'b0, 4'b1000, 1'b0, 32'h7700_0000);
        step(1'b0, 4'b1000, 1'b0, 32'h7800_0000);
        step(1'b0, 4'b1000, 1'b0, 32'h7900_0000);
        step(1'b1, 4'b1000, 1'b0, 32'h7a00_0000);
        step(1'b0, 4'b1100, 1'b0, 32'h7b7b_0000);
        chk("clr_gnt", o_gnt, 4'b0000);
        chk("clr_wen", o_wen, 1'b0);
        chk("clr_busy", o_busy, 1'b0);
        step(1'b0, 4'b1100, 1'b0, 32'h7b7b_0000);
        chk("clr_then_gnt2", o_gnt, 4'b0100);
        chk("clr_then_owner2", o_own, 2'd2);

        // rr_ptr=2 after requester 1 releases: 3 wins over 1.
        do_reset();
        step(1'b0, 4'b0010, 1'b0, 32'h0000_5500);
        step(1'b0, 4'b0010, 1'b0, 32'h0000_5600);
        step(1'b0, 4'b0000, 1'b0, 32'h0000_0000);
        step(1'b0, 4'b1010, 1'b0, 32'h9900_5700);
        step(1'b0, 4'b1010, 1'b0, 32'h9900_5700);
        chk("rr2_gnt3_first", o_gnt, 4'b1000);
        for (int c = 0; c < 4; c++) step(1'b0, 4'b1010, 1'b0, 32'h9900_5700);
        step(1'b0, 4'b1010, 1'b0, 32'h9900_5700);
        chk("rr2_then_gnt1", o_gnt, 4'b0010);

        // Random traffic.
        do_reset();
        for (int c = 0; c < 3000; c++)
            step($urandom_range(0, 99) < 2, N'($urandom), $urandom_range(0, 99) < 30, $urandom);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one synchronous FIFO write port among num_req producers.
- Grants one producer at a time for a bounded burst of up to max_burst beats.
- Drives the FIFO's w_en and data_in directly and honours the FIFO's full flag.
- Sits between producer blocks and a syn_fifo-style buffer, in the same clock domain.

Parameters:
- num_req, 4: number of requesters; must be >= 2.
- data_width, 8: beat width; must match the FIFO's data_width.
- max_burst, 4: maximum beats per grant; must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  synchronous active-high reset.
- req  input  num_req  per-requester request; bit i high means requester i has a beat ready on its slice of req_data.
- req_data  input  num_req*data_width  packed requester data; requester i uses bits [i*data_width +: data_width].
- gnt  output  num_req  registered one-hot grant; all zero when idle.
- accept  output  num_req  combinational; gnt & req & ~fifo_full; a beat from requester i is consumed this cycle.
- owner  output  clog2(num_req)  registered index of the current or last grantee.
- busy  output  1  high in BURST state.
- fifo_full  input  1  FIFO full flag.
- fifo_w_en  output  1  combinational; equals |accept.
- fifo_data  output  data_width  combinational; the req_data slice selected by owner.

Behaviour:
- Reset (clr high at a clk edge) takes effect on that edge.
  - State goes to IDLE.
  - gnt=0, owner=0, rr_ptr=0, beat_cnt=0, busy=0.
  - Outputs therefore settle to accept=0 and fifo_w_en=0.
- clr has priority over all other activity. It applies mid-burst; any beat presented in the clr cycle is not counted by the arbiter.
- State IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the first i with req[i]=1, searching from rr_ptr upward and wrapping modulo num_req.
  - Next edge: gnt=one-hot(i), owner=i, beat_cnt=0, state goes to BURST.
  - No beat is written in IDLE.
  - Grant latency is one cycle from req high to gnt high.
- State BURST:
  - A beat is accepted when req[owner]=1 and fifo_full=0. In that cycle fifo_w_en=1, fifo_data=req_data slice of owner, and beat_cnt increments.
  - If fifo_full=1: no write, gnt held, beat_cnt frozen. There is no timeout.
  - The grant is released at the next edge when either:
    - a beat is accepted with beat_cnt==max_burst-1, or
    - req[owner]=0, in which case the owner has dropped its request and nothing is written that cycle.
  - On release: gnt=0, beat_cnt=0, rr_ptr=(owner==num_req-1)?0:owner+1, state goes to IDLE.
  - One dead cycle in IDLE always separates consecutive grants.
- Sizing:
  - beat_cnt is max(1, clog2(max_burst)) bits wide; its compare value is max_burst-1.
  - owner and rr_ptr are clog2(num_req) bits; wrap is explicit, so num_req need not be a power of two.
- Invariants:
  - gnt is zero or one-hot.
  - accept is a subset of gnt.
  - fifo_w_en is never high while fifo_full is high.
  - At most max_burst beats are written per grant.
- Requester contract:
  - Hold req_data stable while req is high.
  - Present the next beat in the cycle after accept.

Test Plan:
- req=4'b0001 held for 6 beats, fifo_full=0:
  - gnt=0001 one cycle after req, 4 consecutive fifo_w_en.
  - Release, 1 IDLE cycle, regrant, 2 more beats.
  - Data order preserved.
- req=4'b1111 held, fifo_full=0:
  - Grant order 0,1,2,3,0, each burst 4 beats, period 5 cycles.
  - owner tracks grantee; gnt always one-hot.
- Requester 2 granted, fifo_full=1 for 3 cycles after beat 2:
  - fifo_w_en=0 and gnt=0100 held for those cycles.
  - Beats 3-4 written afterwards; then release.
- Requester 0 drops req after 2 accepted beats while req[1]=1:
  - Release next edge; requester 1 granted one cycle later.
  - Exactly 2 beats written from 0.
- clr pulsed mid-burst of requester 3:
  - Next cycle gnt=0, fifo_w_en=0, busy=0.
  - With req=4'b1100 afterwards, requester 2 is granted first (rr_ptr=0).
- After requester 1 is released (rr_ptr=2), req=4'b1010:
  - Requester 3 granted before requester 1.
